dsel_fifo_drain: RTL and testbench
==================================

# dsel_fifo_drain

Read-side drain stage directly downstream of the data-select synchronous FIFO. It pulls words out of the FIFO through its registered-read, 1-cycle-latency port, absorbs that latency in a 2-entry output buffer, and presents a valid/ready stream with programmable burst framing (`m_last`). The stream sustains one beat per cycle when the FIFO is non-empty and the sink is ready.

## Interface

**Parameters**
- `WIDTH`, 64 — data width; must match the FIFO `WIDTH`.
- `LEN_W`, 8 — width of the burst length and beat counter.

**Ports** (clock and reset first)
- `clk`  in  1  — clock.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `enable`  in  1  — permits new FIFO reads.
- `cfg_burst_len`  in  LEN_W  — beats per burst; 0 means 2^LEN_W.
- `fifo_empty`  in  1  — FIFO empty flag (registered in FIFO).
- `fifo_rd_en`  out  1  — FIFO read strobe.
- `fifo_dout`  in  WIDTH  — FIFO read data, valid the cycle after `fifo_rd_en`.
- `m_valid`  out  1  — output beat valid.
- `m_ready`  in  1  — sink accepts beat.
- `m_data`  out  WIDTH  — output beat data.
- `m_last`  out  1  — final beat of the current burst.
- `busy`  out  1  — data buffered or a read in flight.
- `stat_beats`  out  32  — accepted-beat count; present only with `DSEL_DRAIN_STAT_EN`.

## Operation

- **Reset values:** `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `stat_beats`=0.
- **Internal state:**
  - `occ`: 0..2, words held in the buffer.
  - `rd_pend`: a read was issued in the previous cycle.
  - `beat_cnt`: LEN_W bits.
  - `len_q`: LEN_W bits.
- **pop** = `m_valid && m_ready`.
- **Read issue:** `fifo_rd_en` = state RUN && `enable` && !`fifo_empty` && (`occ` + `rd_pend` − pop) < 2.
  - This is combinational from `m_ready`, `fifo_empty`, and the registered state.
  - The buffer can never overflow.
- **Capture:** when `rd_pend`=1, `fifo_dout` is written into the buffer tail at the clock edge. Push and pop in the same cycle are legal; `occ` is then unchanged.
- **Output:** `m_valid` = (`occ`≠0). `m_data` is the buffer head register. Data order is strict FIFO order. `m_data`/`m_valid` hold stable while `m_valid` && !`m_ready`.
- **Burst framing:**
  - `len_q` loads `cfg_burst_len` on every cycle in which `beat_cnt`==0.
  - `m_last` = `m_valid` && (`beat_cnt` == `len_q`−1, mod 2^LEN_W).
  - On pop, `beat_cnt` increments. It wraps to 0 after the last beat.
  - `cfg_burst_len`=1 gives `m_last` on every beat.
  - `cfg_burst_len` must be stable for at least 1 cycle before a burst's first beat. Changes mid-burst take effect at the next burst.
- **FSM** (enum in package):
  - IDLE → RUN when `enable`=1.
  - RUN → DRAIN when `enable`=0.
  - DRAIN → RUN when `enable`=1.
  - DRAIN → IDLE when `occ`==0 && `rd_pend`==0.
  - No reads are issued in IDLE or DRAIN. Buffered and in-flight words are always delivered; no data is dropped.
- `busy` = (`occ`≠0) || `rd_pend`.
- **Asynchronous reset mid-operation:** buffer contents, `beat_cnt`, and the FSM are discarded immediately. The FIFO is reset on the same `rst_n`.

## Timing

- **FIFO read latency:** `fifo_rd_en` high in cycle T → `fifo_dout` valid in T+1 → `m_valid` high in T+2.
- **First beat:** minimum latency from `fifo_empty` falling in cycle T is `m_valid` in T+2.
- **Steady state:** with `occ`=1, `rd_pend`=1 and `m_ready`=1, a read issues every cycle, giving throughput of 1 beat/cycle.
- **Backpressure:** with `m_ready` low, at most 2 words are buffered. Reads stop within the same cycle `occ`+`rd_pend` reaches 2.
- **Resume:** when `m_ready` rises, `fifo_rd_en` may assert in that same cycle, so there is no bubble after the second buffered word.

## Configuration

- **`DSEL_DRAIN_STAT_EN` defined:**
  - The `stat_beats` port and a 32-bit counter are present.
  - The counter increments on each pop and wraps at 2^32.
  - It is cleared only by reset.
- **Not defined:** the port and counter are absent; all other behaviour is identical.

## Structure

- **Package `dsel_pkg`:** FSM state enum (IDLE, RUN, DRAIN) and default constant `DSEL_LEN_W`=8.
- **Sub-module `dsel_skid_buf`:**
  - Contains the 2-entry register buffer.
  - Ports: push / `push_data`, pop, head data, `occ`.
- **Top level:** holds the FSM, read-issue logic, burst counter, and optional statistics counter.

## Test plan

- **Single word:** FIFO holds 0xA5, `enable`=1, `m_ready`=1, `cfg_burst_len`=1 → `fifo_rd_en` for exactly 1 cycle; `m_valid` two cycles later with `m_data`=0xA5, `m_last`=1; then `busy`=0.
- **Streaming:** FIFO holds 0..31, `m_ready`=1, `cfg_burst_len`=8 → 32 consecutive beats in order with no gaps; `m_last` on beats 7, 15, 23, 31.
- **Backpressure:** FIFO holds 10 words, `m_ready` toggles 1/0 every cycle → `occ` never exceeds 2; all 10 words are delivered in order; `m_data` stays stable while stalled.
- **Drain:** FIFO holds 20 words; `enable` drops after 5 reads have been issued → exactly 5 words are delivered, the FSM reaches IDLE, and 15 words remain in the FIFO.
- **Length 0 and reset:** with `cfg_burst_len`=0, `m_last` occurs only on beat 255. Asserting `rst_n`=0 mid-stream forces all outputs to their reset values within the same cycle.
- **Statistics (`DSEL_DRAIN_STAT_EN`):** after 100 accepted beats, `stat_beats`=100.

Source files
------------

// File: rtl/dsel_fifo_drain_pkg.sv
// rtl/dsel_fifo_drain_pkg.sv - shared state encoding and defaults for the FIFO drain stage
package dsel_pkg;

    localparam int DSEL_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dsel_state_e;

endpackage

// File: rtl/dsel_fifo_drain_if.sv
// rtl/dsel_fifo_drain_if.sv - FIFO read port and output beat stream bundle
interface dsel_fifo_drain_if #(
    parameter int WIDTH = 64
);
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty,
        output fifo_rd_en,
        input  fifo_dout,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        input  fifo_rd_en,
        output fifo_dout,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last
    );
endinterface

// File: rtl/dsel_skid_buf.sv
// rtl/dsel_skid_buf.sv - 2-entry register buffer absorbing the FIFO read latency
module dsel_skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;

    // Head stays put while stalled; the caller never pushes into a full buffer without popping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (i_push) begin
                        r_head <= i_push_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (i_push && i_pop) begin
                        r_head <= i_push_data;
                    end else if (i_push) begin
                        r_tail <= i_push_data;
                        r_occ  <= 2'd2;
                    end else if (i_pop) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_push_data;
                        end else begin
                            r_occ  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    assign o_head = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/dsel_fifo_drain.sv
// rtl/dsel_fifo_drain.sv - FIFO drain stage with burst framing; DSEL_DRAIN_STAT_EN adds stat_beats
module dsel_fifo_drain
    import dsel_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LEN_W = DSEL_LEN_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [LEN_W-1:0]    cfg_burst_len,
    dsel_fifo_drain_if.master   bus,
    output logic                busy
`ifdef DSEL_DRAIN_STAT_EN
    ,
    output logic [31:0]         stat_beats
`endif
);

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    dsel_state_e      r_state;
    logic             r_rd_pend;
    logic [LEN_W-1:0] r_beat_cnt;
    logic [LEN_W-1:0] r_len_q;

    logic [1:0]       w_occ;
    logic [WIDTH-1:0] w_head;
    logic             w_valid;
    logic             w_pop;
    logic [2:0]       w_level;
    logic             w_room;
    logic             w_rd_en;
    logic [LEN_W-1:0] w_len_m1;
    logic             w_last_beat;

    assign w_valid = (w_occ != 2'd0);
    assign w_pop   = w_valid && bus.m_ready;

    // Count words held plus the one in flight; a same-cycle pop frees a slot for this read.
    assign w_level = {1'b0, w_occ} + {2'b00, r_rd_pend};
    assign w_room  = (w_level < (3'd2 + {2'b00, w_pop}));
    assign w_rd_en = (r_state == RUN) && enable && !bus.fifo_empty && w_room;

    // Length 0 wraps to all-ones here, giving a 2^LEN_W beat burst.
    assign w_len_m1    = r_len_q - ONE;
    assign w_last_beat = (r_beat_cnt == w_len_m1);

    dsel_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_rd_pend),
        .i_push_data (bus.fifo_dout),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_occ       (w_occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rd_pend <= 1'b0;
        end else begin
            r_rd_pend <= w_rd_en;
            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= DRAIN;
                DRAIN: begin
                    if (enable) begin
                        r_state <= RUN;
                    end else if ((w_occ == 2'd0) && !r_rd_pend) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Burst length is sampled between bursts so mid-burst changes apply to the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt <= '0;
            r_len_q    <= '0;
        end else begin
            if (r_beat_cnt == '0) begin
                r_len_q <= cfg_burst_len;
            end
            if (w_pop) begin
                r_beat_cnt <= w_last_beat ? '0 : (r_beat_cnt + ONE);
            end
        end
    end

`ifdef DSEL_DRAIN_STAT_EN
    logic [31:0] r_stat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat <= '0;
        end else if (w_pop) begin
            r_stat <= r_stat + 32'd1;
        end
    end

    assign stat_beats = r_stat;
`endif

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_head;
    assign bus.m_last     = w_valid && w_last_beat;
    assign busy           = w_valid || r_rd_pend;

endmodule

// File: tb/tb_dsel_fifo_drain.sv
// tb/tb_dsel_fifo_drain.sv - directed vector bench for dsel_fifo_drain
module tb_dsel_fifo_drain;
    import dsel_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] cfg_burst_len = 8'd1;
    logic       busy;
`ifdef DSEL_DRAIN_STAT_EN
    logic [31:0] stat_beats;
`endif

    dsel_fifo_drain_if #(.WIDTH(64)) bus ();

    dsel_fifo_drain #(.WIDTH(64), .LEN_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_burst_len (cfg_burst_len),
        .bus           (bus),
        .busy          (busy)
`ifdef DSEL_DRAIN_STAT_EN
        ,
        .stat_beats    (stat_beats)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [63:0] q[$];
    logic [63:0] rx_data[$];
    logic        rx_last[$];
    int          rx_cyc[$];
    int          n_reads, n_pops, stall_err, max_out, cyc;
    logic        prev_stall;
    logic [63:0] prev_data;

    // FIFO model: registered empty flag, data one cycle after the read strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            bus.fifo_empty <= 1'b1;
            bus.fifo_dout  <= '0;
        end else begin
            if (bus.fifo_rd_en && (q.size() != 0)) bus.fifo_dout <= q.pop_front();
            bus.fifo_empty <= (q.size() == 0);
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data.delete();
            rx_last.delete();
            rx_cyc.delete();
            n_reads    <= 0;
            n_pops     <= 0;
            stall_err  <= 0;
            max_out    <= 0;
            cyc        <= 0;
            prev_stall <= 1'b0;
            prev_data  <= '0;
        end else begin
            cyc <= cyc + 1;
            if (prev_stall && (!bus.m_valid || (bus.m_data != prev_data))) stall_err <= stall_err + 1;
            prev_stall <= bus.m_valid && !bus.m_ready;
            prev_data  <= bus.m_data;
            if (bus.fifo_rd_en) n_reads <= n_reads + 1;
            if (bus.m_valid && bus.m_ready) begin
                rx_data.push_back(bus.m_data);
                rx_last.push_back(bus.m_last);
                rx_cyc.push_back(cyc);
                n_pops <= n_pops + 1;
            end
            if ((n_reads + int'(bus.fifo_rd_en)) - (n_pops + int'(bus.m_valid && bus.m_ready)) > max_out)
                max_out <= (n_reads + int'(bus.fifo_rd_en)) - (n_pops + int'(bus.m_valid && bus.m_ready));
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] blen);
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b0;
        bus.m_ready = 1'b0;
        cfg_burst_len = blen;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input bit toggle);
        for (int c = 0; c < budget && n_pops < n; c++) begin
            @(negedge clk);
            if (toggle) bus.m_ready = !bus.m_ready;
        end
        bus.m_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic load(input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) q.push_back(base + 64'(i));
    endtask

    function automatic int order_errs(input logic [63:0] base);
        int e = 0;
        for (int i = 0; i < rx_data.size(); i++) if (rx_data[i] !== base + 64'(i)) e++;
        return e;
    endfunction

    typedef struct {
        int          nwords;
        logic [7:0]  blen;
        bit          toggle;
        logic [63:0] base;
        logic [31:0] exp_last;
        int          exp_span;
    } vec_t;

    vec_t vt[6];
    logic [31:0] mask;
    int nl;

    initial begin
        bus.m_ready = 1'b0;
        vt[0] = '{1,  8'd1, 1'b0, 64'hA5,                  32'h0000_0001, 0};
        vt[1] = '{32, 8'd8, 1'b0, 64'h0,                   32'h8080_8080, 31};
        vt[2] = '{10, 8'd1, 1'b1, 64'h100,                 32'h0000_03FF, -1};
        vt[3] = '{10, 8'd4, 1'b1, 64'hDEAD_0000,           32'h0000_0088, -1};
        vt[4] = '{12, 8'd3, 1'b0, 64'h5555_0000_0000_0000, 32'h0000_0924, 11};
        vt[5] = '{5,  8'd2, 1'b0, 64'h77,                  32'h0000_000A, 4};

        do_reset(8'd1);
        @(negedge clk);
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_last", bus.m_last, 0);
        chk("rst_busy", busy, 0);
`ifdef DSEL_DRAIN_STAT_EN
        chk("rst_stat", stat_beats, 0);
`endif

        // Single word latency: rd_en at T, data at T+1, m_valid at T+2.
        do_reset(8'd1);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (2) @(negedge clk);
        q.push_back(64'hA5);
        @(negedge clk);
        chk("lat_rd_en_T", bus.fifo_rd_en, 1);
        chk("lat_valid_T", bus.m_valid, 0);
        @(negedge clk);
        chk("lat_rd_en_T1", bus.fifo_rd_en, 0);
        chk("lat_valid_T1", bus.m_valid, 0);
        chk("lat_busy_T1", busy, 1);
        @(negedge clk);
        chk("lat_valid_T2", bus.m_valid, 1);
        chk("lat_data_T2", bus.m_data, 64'hA5);
        chk("lat_last_T2", bus.m_last, 1);
        @(negedge clk);
        chk("lat_valid_T3", bus.m_valid, 0);
        chk("lat_busy_T3", busy, 0);
        chk("lat_reads", n_reads, 1);

        for (int k = 0; k < 6; k++) begin
            do_reset(vt[k].blen);
            load(vt[k].nwords, vt[k].base);
            enable = 1'b1;
            bus.m_ready = 1'b1;
            run_until(vt[k].nwords, 200, vt[k].toggle);
            chk($sformatf("v%0d_beats", k), n_pops, vt[k].nwords);
            chk($sformatf("v%0d_reads", k), n_reads, vt[k].nwords);
            chk($sformatf("v%0d_order_errs", k), order_errs(vt[k].base), 0);
            mask = '0;
            for (int i = 0; i < rx_last.size() && i < 32; i++) mask[i] = rx_last[i];
            chk($sformatf("v%0d_last_mask", k), mask, vt[k].exp_last);
            chk($sformatf("v%0d_stall_stable_errs", k), stall_err, 0);
            chk($sformatf("v%0d_outstanding_le2", k), (max_out <= 2), 1);
            chk($sformatf("v%0d_busy_end", k), busy, 0);
            if (vt[k].exp_span >= 0 && rx_cyc.size() == vt[k].nwords)
                chk($sformatf("v%0d_span", k), rx_cyc[vt[k].nwords-1] - rx_cyc[0], vt[k].exp_span);
        end

        // Drain: stop reads after five have been issued.
        do_reset(8'd4);
        load(20, 64'h2000);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 50 && n_reads < 5; c++) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        chk("drain_reads", n_reads, 5);
        chk("drain_beats", n_pops, 5);
        chk("drain_order_errs", order_errs(64'h2000), 0);
        chk("drain_fifo_left", q.size(), 15);
        chk("drain_idle", dut.r_state, IDLE);
        chk("drain_busy", busy, 0);

        // Length 0 means a 256 beat burst.
        do_reset(8'd0);
        load(256, 64'h0);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        run_until(256, 600, 1'b0);
        nl = 0;
        foreach (rx_last[i]) if (rx_last[i]) nl++;
        chk("len0_beats", n_pops, 256);
        chk("len0_last_count", nl, 1);
        if (rx_last.size() == 256) chk("len0_last_at_255", rx_last[255], 1);
        chk("len0_order_errs", order_errs(64'h0), 0);

`ifdef DSEL_DRAIN_STAT_EN
        do_reset(8'd8);
        load(100, 64'h300);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        run_until(100, 300, 1'b0);
        chk("stat_100", stat_beats, 100);
`endif

        // Asynchronous reset in the middle of a stream.
        do_reset(8'd8);
        load(40, 64'h4000);
        enable = 1'b1;
        bus.m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("midrst_valid_before", bus.m_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", bus.fifo_rd_en, 0);
        chk("midrst_valid", bus.m_valid, 0);
        chk("midrst_data", bus.m_data, 0);
        chk("midrst_last", bus.m_last, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
